// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants, classification helpers and the argmax FSM state type.
package bf16_pkg;

    localparam int          BF16_W        = 16;
    localparam logic [7:0]  BF16_EXP_ONES = 8'hFF;
    localparam logic [15:0] BF16_QNAN     = 16'h7FC0;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } argmax_state_t;

    function automatic logic is_nan(input logic [BF16_W-1:0] x);
        return (x[14:7] == BF16_EXP_ONES) && (x[6:0] != 7'd0);
    endfunction

    function automatic logic is_zero(input logic [BF16_W-1:0] x);
        return x[14:0] == 15'd0;
    endfunction

endpackage

// File: rtl/bf16_greater.sv
// Strict a > b on bfloat16 bit patterns: sign-magnitude order, +0 == -0, NaN-unaware.
module bf16_greater
    import bf16_pkg::*;
(
    input  logic [BF16_W-1:0] a,
    input  logic [BF16_W-1:0] b,
    output logic              a_gt_b
);

    always_comb begin
        a_gt_b = 1'b0;
        if (is_zero(a) && is_zero(b)) begin
            a_gt_b = 1'b0;
        end else if (a[15] != b[15]) begin
            a_gt_b = !a[15];
        end else if (!a[15]) begin
            a_gt_b = a[14:0] > b[14:0];
        end else begin
            // Both negative: smaller magnitude is the larger value.
            a_gt_b = a[14:0] < b[14:0];
        end
    end

endmodule

// File: rtl/bf16_argmax_stream.sv
// Streaming argmax over a frame of NUM_CLASSES bfloat16 scores with a single comparator
// and a registered {index, value} result held until the consumer accepts it.
module bf16_argmax_stream
    import bf16_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BF16_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [BF16_W-1:0] out_value,
    output logic              out_nan
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t     state_q, state_d;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [BF16_W-1:0] best_q;
    logic              best_valid_q;

    logic              in_xfer, out_xfer, last, take, x_gt_best;
    logic              fin_valid;
    logic [IDX_W-1:0]  fin_idx;
    logic [BF16_W-1:0] fin_value;

    bf16_greater u_greater (
        .a      (in_data),
        .b      (best_q),
        .a_gt_b (x_gt_best)
    );

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign last     = in_xfer && (cnt_q == LAST_IDX);
    assign take     = in_xfer && !is_nan(in_data) && (!best_valid_q || x_gt_best);

    // Frame result as it stands including the element accepted this cycle.
    assign fin_valid = take || best_valid_q;
    assign fin_idx   = take ? cnt_q : best_idx_q;
    assign fin_value = take ? in_data : best_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last)     state_d = HOLD;
            HOLD:    if (out_xfer) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            out_index    <= '1;
            out_value    <= '0;
            out_nan      <= 1'b0;
        end else begin
            if (take) begin
                best_valid_q <= 1'b1;
            end
            if (in_xfer) begin
                cnt_q <= last ? '0 : cnt_q + IDX_W'(1);
            end
            if (last) begin
                out_index <= fin_valid ? fin_idx : '1;
                out_value <= fin_valid ? fin_value : BF16_QNAN;
                out_nan   <= !fin_valid;
            end
            if (out_xfer) begin
                best_valid_q <= 1'b0;
            end
        end
    end

    // Best value/index are qualified by best_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            best_q     <= in_data;
            best_idx_q <= cnt_q;
        end
    end

endmodule

// File: tb/tb_bf16_argmax_stream.sv
// Directed and randomized frames against a real-valued argmax reference model.
module tb_bf16_argmax_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_nan;
    logic [15:0] in_data, out_value;
    logic [3:0]  out_index;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_nan;
    logic [15:0] b_in_data, b_out_value;
    logic [2:0]  b_out_index;

    int errors = 0;
    int checks = 0;

    logic [15:0] frm[$];

    always #5 clk = ~clk;

    bf16_argmax_stream #(.NUM_CLASSES(10), .IDX_W(4)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value), .out_nan(out_nan)
    );

    bf16_argmax_stream #(.NUM_CLASSES(4), .IDX_W(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_index(b_out_index), .out_value(b_out_value), .out_nan(b_out_nan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Numeric value of a non-NaN bfloat16; infinities map to +-1e300.
    function automatic real bf2real(input logic [15:0] x);
        int  e;
        real mag;
        e = int'(x[14:7]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = real'(int'(x[6:0])) * (2.0 ** (-133.0));
        else             mag = real'(128 + int'(x[6:0])) * (2.0 ** real'(e - 134));
        return x[15] ? -mag : mag;
    endfunction

    function automatic bit ref_is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    // First index holding the largest non-NaN value, or -1 if none.
    function automatic int ref_argmax(input logic [15:0] q[$]);
        int  bi;
        real bv;
        bi = -1;
        bv = 0.0;
        foreach (q[i]) begin
            if (!ref_is_nan(q[i]) && (bi < 0 || bf2real(q[i]) > bv)) begin
                bi = i;
                bv = bf2real(q[i]);
            end
        end
        return bi;
    endfunction

    function automatic logic [15:0] rand_score();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: return {r[15], 8'hFF, r[6:0] | 7'd1};
            1: return {r[15], 15'd0};
            2: return {r[15], 8'hFF, 7'd0};
            3: return {r[15], 8'd0, r[6:0]};
            4: return r[0] ? 16'h3F80 : 16'hBF80;
            default: return (r[14:7] == 8'hFF) ? {r[15], 8'hFE, r[6:0]} : r;
        endcase
    endfunction

    // Sends frm to dut_a (optionally with idle gaps), checks result, holds it, releases it.
    task automatic run_a(input string name, input bit gaps, input int hold);
        int          i, bi, budget;
        bit          sent, rdy;
        logic [3:0]  e_idx, h_idx;
        logic [15:0] e_val, h_val;
        i = 0;
        budget = 0;
        while (i < 10 && budget < 300) begin
            sent = !(gaps && $urandom_range(0, 2) == 0);
            in_valid = sent;
            in_data  = sent ? frm[i] : 16'($urandom);
            rdy = in_ready;
            chk({name, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
            budget++;
            if (sent && rdy) i++;
        end
        in_valid = 1'b0;
        chk({name, "_accepted"}, i, 10);
        bi    = ref_argmax(frm);
        e_idx = (bi < 0) ? 4'hF : 4'(bi);
        e_val = (bi < 0) ? 16'h7FC0 : frm[bi];
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_index"}, {28'd0, out_index}, {28'd0, e_idx});
        chk({name, "_value"}, {16'd0, out_value}, {16'd0, e_val});
        chk({name, "_nan"}, {31'd0, out_nan}, {31'd0, bi < 0});
        h_idx = e_idx;
        h_val = e_val;
        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, "_hold_index"}, {28'd0, out_index}, {28'd0, h_idx});
            chk({name, "_hold_value"}, {16'd0, out_value}, {16'd0, h_val});
            chk({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        chk({name, "_xfer_in_ready"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_a(input string name);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_index"}, {28'd0, out_index}, 32'hF);
        chk({name, "_value"}, {16'd0, out_value}, 32'd0);
        chk({name, "_nan"}, {31'd0, out_nan}, 32'd0);
    endtask

    initial begin
        int          bi;
        logic [15:0] b_frm[4];

        reset = 1'b1;
        in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'd0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("rst");
        chk("rst_b_index", {29'd0, b_out_index}, 32'h7);
        chk("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        frm = '{16'h3F80, 16'h3F00, 16'h4000, 16'hBF80, 16'h0000,
                16'h3FC0, 16'h3E80, 16'h4020, 16'h3F80, 16'h4010};
        run_a("case1", 1'b0, 0);
        run_a("case1_gaps", 1'b1, 5);

        frm = '{16'h3F80, 16'h3F80, 16'h4040, 16'h3F80, 16'h3F80,
                16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        run_a("tie", 1'b0, 0);
        frm = '{16'hBF80, 16'h8000, 16'hBF80, 16'h0000, 16'hBF80,
                16'hBF80, 16'hBF80, 16'hBF80, 16'hBF80, 16'hBF80};
        run_a("zero_sign", 1'b0, 1);
        frm = '{16'hC000, 16'hBF80, 16'h7FC0, 16'hC040, 16'hBF00,
                16'hFFC1, 16'hC100, 16'hBF40, 16'hC080, 16'hFF80};
        run_a("neg_nan", 1'b1, 0);
        frm = '{16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0,
                16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0};
        run_a("all_nan", 1'b0, 2);

        for (int f = 0; f < 8; f++) begin
            frm.delete();
            for (int k = 0; k < 10; k++) frm.push_back(rand_score());
            run_a($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Partial frame whose stale maximum must not survive a reset.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 0) ? 16'h7F7F : 16'h3F80;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_a("midrst");
        reset = 1'b0;
        frm = '{16'h3F80, 16'h3F00, 16'h4000, 16'hBF80, 16'h0000,
                16'h3FC0, 16'h3E80, 16'h4020, 16'h3F80, 16'h4010};
        run_a("after_rst", 1'b0, 0);

        b_frm = '{16'h0001, 16'h0000, 16'h0080, 16'h007F};
        frm.delete();
        foreach (b_frm[k]) frm.push_back(b_frm[k]);
        bi = ref_argmax(frm);
        for (int k = 0; k < 4; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = b_frm[k];
            chk("b_in_ready", {31'd0, b_in_ready}, 32'd1);
            chk("b_no_early_valid", {31'd0, b_out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        chk("b_valid", {31'd0, b_out_valid}, 32'd1);
        chk("b_index", {29'd0, b_out_index}, bi);
        chk("b_value", {16'd0, b_out_value}, {16'd0, frm[bi]});
        chk("b_nan", {31'd0, b_out_nan}, 32'd0);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_post_valid", {31'd0, b_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
